// File: rtl/fbuf_pkg.sv
// fbuf_pkg: shared defaults, FSM states and clear-counter sizing for the feature buffer
package fbuf_pkg;
   localparam int FBUF_ADDR_W = 11;
   localparam int FBUF_DATA_W = 512;
   localparam int FBUF_DEPTH = 2048;
   typedef enum logic {FBUF_IDLE, FBUF_CLEAR} fbuf_state_e;
   function automatic int fbuf_cnt_w(input int depth);
      return depth > 1 ? $clog2(depth) : 1;
   endfunction
   localparam int FBUF_CNT_W = fbuf_cnt_w(FBUF_DEPTH);
endpackage

// File: rtl/fbuf_rd_pipe.sv
// fbuf_rd_pipe: fixed-latency read return path with same-cycle write bypass at stage 0
module fbuf_rd_pipe #(
   parameter int DATA_W = 512,
   parameter int RD_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              acc,
   input  logic              byp,
   input  logic [DATA_W-1:0] byp_data,
   input  logic [DATA_W-1:0] ram_q,
   output logic              rd_data_valid,
   output logic [DATA_W-1:0] rd_data
);
   logic [RD_LAT-1:0] v;
   logic b0;
   logic [DATA_W-1:0] bd0;
   logic [DATA_W-1:0] dr [RD_LAT];
   logic [DATA_W-1:0] dc [RD_LAT];
   always_ff @(posedge clk)
      if (rst) begin
         v <= '0;
         b0 <= 1'b0;
         bd0 <= '0;
         for (int k = 0; k < RD_LAT; k++) dr[k] <= '0;
      end else begin
         v[0] <= acc;
         if (acc) begin
            b0 <= byp;
            bd0 <= byp_data;
         end
         for (int k = 1; k < RD_LAT; k++) begin
            v[k] <= v[k-1];
            if (v[k-1]) dr[k] <= dc[k-1];
         end
      end
   // stages only advance on valid beats, so the output holds its last value between beats
   always_comb begin
      dc[0] = b0 ? bd0 : ram_q;
      for (int k = 1; k < RD_LAT; k++) dc[k] = dr[k];
   end
   assign rd_data_valid = v[RD_LAT-1];
   assign rd_data = dc[RD_LAT-1];
endmodule

// File: rtl/feature_buffer_responder.sv
// feature_buffer_responder: one feature bank serving kernel reads/writes plus a zero-clear sweep
module feature_buffer_responder
   import fbuf_pkg::*;
#(
   parameter int ADDR_W = FBUF_ADDR_W,
   parameter int DATA_W = FBUF_DATA_W,
   parameter int DEPTH  = FBUF_DEPTH,
   parameter int RD_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_addr_valid,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_data_valid,
   output logic [DATA_W-1:0] rd_data,
   input  logic              wr_addr_valid,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic              wr_data_valid,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              clear_start,
   output logic              busy,
   output logic              clear_done,
   output logic              err
);
   localparam int CW = fbuf_cnt_w(DEPTH);
   localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);
   localparam logic [CW-1:0] LAST = CW'(DEPTH-1);
   fbuf_state_e state, state_nx;
   logic [CW-1:0] cnt, waddr;
   logic done_q, err_q, err_set, idle, rd_in, wr_in, rd_acc, wr_acc, byp, we;
   logic [DATA_W-1:0] wdata, ram_q;
   logic [DATA_W-1:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (rst) state <= FBUF_IDLE;
      else state <= state_nx;
   always_comb
      state_nx = state == FBUF_IDLE ? (clear_start ? FBUF_CLEAR : FBUF_IDLE)
                                    : (cnt == LAST ? FBUF_IDLE : FBUF_CLEAR);
   always_comb begin
      busy = state == FBUF_CLEAR;
      clear_done = done_q;
      err = err_q;
   end
   always_comb begin
      idle = state == FBUF_IDLE;
      rd_in = {1'b0, rd_addr} < LIMIT;
      wr_in = {1'b0, wr_addr} < LIMIT;
      rd_acc = idle && rd_addr_valid && rd_in;
      wr_acc = idle && wr_addr_valid && wr_data_valid && wr_in;
      byp = wr_acc && wr_addr == rd_addr;
      err_set = (wr_addr_valid != wr_data_valid) || (rd_addr_valid && !rd_acc)
                || (wr_addr_valid && wr_data_valid && !wr_acc);
      we = busy || wr_acc;
      waddr = busy ? cnt : wr_addr[CW-1:0];
      wdata = busy ? '0 : wr_data;
   end
   always_ff @(posedge clk)
      if (rst) begin
         cnt <= '0;
         done_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         cnt <= busy && cnt != LAST ? cnt + 1'b1 : '0;
         done_q <= busy && cnt == LAST;
         if (err_set) err_q <= 1'b1;
      end
   // contents survive reset; only the read register is cleared
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   always_ff @(posedge clk)
      if (rst) ram_q <= '0;
      else if (rd_acc) ram_q <= mem[rd_addr[CW-1:0]];
   fbuf_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_rd_pipe (
      .clk(clk),
      .rst(rst),
      .acc(rd_acc),
      .byp(byp),
      .byp_data(wr_data),
      .ram_q(ram_q),
      .rd_data_valid(rd_data_valid),
      .rd_data(rd_data)
   );
endmodule
